// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, plus the playfield bounds shared with the colour stage.
package vga_timing_pkg;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_VIS_START = 144;
    localparam int VGA_H_VIS_END   = 783;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_VIS_START = 35;
    localparam int VGA_V_VIS_END   = 514;

    localparam int PLAY_X_MIN = 150;
    localparam int PLAY_Y_MIN = 34;
    localparam int PLAY_X_MAX = 630;
    localparam int PLAY_Y_MAX = 514;
endpackage

// File: rtl/tick_divider.sv
// Modulo-N counter that advances when en is high.
// wrap is decoded combinationally and is high in the cycle whose edge returns the count to 0.
module tick_divider #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);
    localparam int W = $clog2(N) + 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing for the colour stage: pixel enable, h/v counters, registered syncs and bright,
// frame pulse and game-rate pulse. Syncs/bright come from next-state counts, so they line up with the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV         = 4,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_VIS_START     = VGA_H_VIS_START,
    parameter int H_VIS_END       = VGA_H_VIS_END,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_VIS_START     = VGA_V_VIS_START,
    parameter int V_VIS_END       = VGA_V_VIS_END,
    parameter int FRAMES_PER_TICK = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_tick,
    output logic       game_tick
);
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (!(H_SYNC < H_VIS_START && H_VIS_START <= H_VIS_END && H_VIS_END < H_TOTAL)) begin : g_bad_h
        $error("vga_timing_gen: horizontal timing ordering violated");
    end
    if (!(V_SYNC < V_VIS_START && V_VIS_START <= V_VIS_END && V_VIS_END < V_TOTAL)) begin : g_bad_v
        $error("vga_timing_gen: vertical timing ordering violated");
    end
    if (CLK_DIV < 1 || FRAMES_PER_TICK < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV and FRAMES_PER_TICK must be at least 1");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] V_SW   = 10'(V_SYNC);
    localparam logic [9:0] H_VS   = 10'(H_VIS_START);
    localparam logic [9:0] H_VE   = 10'(H_VIS_END);
    localparam logic [9:0] V_VS   = 10'(V_VIS_START);
    localparam logic [9:0] V_VE   = 10'(V_VIS_END);

    logic       pix_wrap;
    logic       frame_wrap;
    logic       game_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    tick_divider #(.N(CLK_DIV)) u_pix_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .wrap (pix_wrap)
    );

    // Gated with rst so a CLK_DIV=1 build still shows pix_en=0 while held in reset.
    assign pix_en = pix_wrap && !rst;

    always_comb begin
        h_nxt = hCount;
        v_nxt = vCount;
        if (pix_en) begin
            if (hCount == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vCount == V_LAST) ? '0 : vCount + 10'd1;
            end else begin
                h_nxt = hCount + 10'd1;
            end
        end
    end

    assign frame_wrap = pix_en && (hCount == H_LAST) && (vCount == V_LAST);

    tick_divider #(.N(FRAMES_PER_TICK)) u_game_div (
        .clk  (clk),
        .rst  (rst),
        .en   (frame_wrap),
        .wrap (game_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount     <= '0;
            vCount     <= '0;
            bright     <= 1'b0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            frame_tick <= 1'b0;
            game_tick  <= 1'b0;
        end else begin
            hCount     <= h_nxt;
            vCount     <= v_nxt;
            hSync      <= (h_nxt >= H_SW);
            vSync      <= (v_nxt >= V_SW);
            bright     <= (h_nxt >= H_VS) && (h_nxt <= H_VE) && (v_nxt >= V_VS) && (v_nxt <= V_VE);
            frame_tick <= frame_wrap;
            game_tick  <= game_wrap;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: nominal build for reset/line timing, shrunken rasters for frame/game pulses.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       bright;
        logic       hs;
        logic       vs;
        logic       ft;
        logic       gt;
    } out_t;

    localparam int SD = 2, SHT = 20, SHS = 3, SH0 = 5, SH1 = 16;
    localparam int SVT = 12, SVS = 2, SV0 = 4, SV1 = 9, SF = 4;
    localparam int SFRAME = SD * SHT * SVT;
    localparam int OFRAME = SHT * SVT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Edges since reset release; state after edge k is what the outputs show during cycle k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic f_pix, f_bright, f_hs, f_vs, f_ft, f_gt;
    logic s_pix, s_bright, s_hs, s_vs, s_ft, s_gt;
    logic o_pix, o_bright, o_hs, o_vs, o_ft, o_gt;
    logic [9:0] f_h, f_v, s_h, s_v, o_h, o_v;
    out_t full_o, small_o, one_o;

    assign full_o  = {f_pix, f_h, f_v, f_bright, f_hs, f_vs, f_ft, f_gt};
    assign small_o = {s_pix, s_h, s_v, s_bright, s_hs, s_vs, s_ft, s_gt};
    assign one_o   = {o_pix, o_h, o_v, o_bright, o_hs, o_vs, o_ft, o_gt};

    vga_timing_gen u_full (
        .clk(clk), .rst(rst), .pix_en(f_pix), .hCount(f_h), .vCount(f_v), .bright(f_bright),
        .hSync(f_hs), .vSync(f_vs), .frame_tick(f_ft), .game_tick(f_gt)
    );

    vga_timing_gen #(
        .CLK_DIV(SD), .H_TOTAL(SHT), .H_SYNC(SHS), .H_VIS_START(SH0), .H_VIS_END(SH1),
        .V_TOTAL(SVT), .V_SYNC(SVS), .V_VIS_START(SV0), .V_VIS_END(SV1), .FRAMES_PER_TICK(SF)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(s_pix), .hCount(s_h), .vCount(s_v), .bright(s_bright),
        .hSync(s_hs), .vSync(s_vs), .frame_tick(s_ft), .game_tick(s_gt)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(SHT), .H_SYNC(SHS), .H_VIS_START(SH0), .H_VIS_END(SH1),
        .V_TOTAL(SVT), .V_SYNC(SVS), .V_VIS_START(SV0), .V_VIS_END(SV1), .FRAMES_PER_TICK(1)
    ) u_one (
        .clk(clk), .rst(rst), .pix_en(o_pix), .hCount(o_h), .vCount(o_v), .bright(o_bright),
        .hSync(o_hs), .vSync(o_vs), .frame_tick(o_ft), .game_tick(o_gt)
    );

    // Closed-form raster model: k edges since release -> k/d pixel steps.
    function automatic out_t model(int k, int d, int ht, int hsw, int h0, int h1,
                                   int vt, int vsw, int v0, int v1, int f);
        out_t o;
        int p, h, v, fr;
        p = k / d;
        h = p % ht;
        v = (p / ht) % vt;
        fr = p / (ht * vt);
        o.pix    = ((k % d) == d - 1);
        o.h      = 10'(h);
        o.v      = 10'(v);
        o.bright = (h >= h0) && (h <= h1) && (v >= v0) && (v <= v1);
        o.hs     = (h >= hsw);
        o.vs     = (v >= vsw);
        o.ft     = (k > 0) && (k % d == 0) && (p % (ht * vt) == 0);
        o.gt     = o.ft && (fr % f == 0);
        return o;
    endfunction

    function automatic out_t exp_full(int k);
        return model(k, 4, 800, 96, 144, 783, 525, 2, 35, 514, 4);
    endfunction

    function automatic out_t exp_small(int k);
        return model(k, SD, SHT, SHS, SH0, SH1, SVT, SVS, SV0, SV1, SF);
    endfunction

    task automatic test_reset();
        int pq[$];
        int first_pix;
        first_pix = -1;
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks += 3;
            if (full_o !== '0)  begin errors++; $display("FAIL reset_full got=%h exp=0", full_o); end
            if (small_o !== '0) begin errors++; $display("FAIL reset_small got=%h exp=0", small_o); end
            if (one_o !== '0)   begin errors++; $display("FAIL reset_one got=%h exp=0", one_o); end
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) if (k % 4 == 3) pq.push_back(k);
        #1;
        checks += 2;
        if (o_pix !== 1'b1) begin errors++; $display("FAIL pix_div1_cycle0 got=%b exp=1", o_pix); end
        if (full_o !== '0)  begin errors++; $display("FAIL release_no_pulse got=%h exp=0", full_o); end
        for (int i = 0; i < 40; i++) begin
            if (f_pix === 1'b1) begin
                checks++;
                if (first_pix < 0) first_pix = cyc;
                if (pq.size() == 0) begin
                    errors++; $display("FAIL pix_en_extra cyc=%0d got=1 exp=0", cyc);
                end else begin
                    int e;
                    e = pq.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL pix_en_cycle got=%0d exp=%0d", cyc, e); end
                end
            end
            if (cyc == 4) begin
                checks++;
                if (f_h !== 10'd1) begin errors++; $display("FAIL hcount_after_4 got=%0d exp=1", f_h); end
            end
            @(negedge clk);
        end
        checks += 2;
        if (first_pix !== 3) begin errors++; $display("FAIL first_pix_en got=%0d exp=3", first_pix); end
        if (pq.size() != 0)  begin errors++; $display("FAIL pix_en_missing left=%0d exp=0", pq.size()); end
    endtask

    task automatic test_line_wrap();
        out_t sb[$];
        out_t e;
        int low, guard;
        low = 0;
        guard = 0;
        while (cyc < 2 * 4 * 800 && guard < 10000) begin
            sb.push_back(exp_full(cyc + 1));
            @(negedge clk);
            guard++;
            e = sb.pop_front();
            checks++;
            if (full_o !== e) begin errors++; $display("FAIL line_wrap cyc=%0d got=%h exp=%h", cyc, full_o, e); end
            if (cyc >= 3200 && cyc < 6400 && f_hs === 1'b0) low++;
            if (cyc == 3200) begin
                checks++;
                if ({f_h, f_v} !== {10'd0, 10'd1})
                    begin errors++; $display("FAIL line_wrap_counts got=%0d,%0d exp=0,1", f_h, f_v); end
            end
        end
        checks++;
        if (low !== 384) begin errors++; $display("FAIL hsync_low_width got=%0d exp=384", low); end
    endtask

    task automatic test_visible_window();
        out_t sb[$];
        out_t e;
        int guard, nb, nvs;
        guard = 0; nb = 0; nvs = 0;
        while (cyc % SFRAME != 0 && guard < 2 * SFRAME) begin @(negedge clk); guard++; end
        checks++;
        if (cyc % SFRAME != 0) begin errors++; $display("FAIL window_align got=%0d exp=0", cyc % SFRAME); end
        sb.push_back(exp_small(cyc));
        repeat (SFRAME) begin
            e = sb.pop_front();
            checks++;
            if (small_o !== e) begin errors++; $display("FAIL window cyc=%0d got=%h exp=%h", cyc, small_o, e); end
            if (s_bright === 1'b1) nb++;
            if (s_vs === 1'b0) nvs++;
            sb.push_back(exp_small(cyc + 1));
            @(negedge clk);
        end
        checks += 2;
        if (nb !== 144) begin errors++; $display("FAIL bright_cycles got=%0d exp=144", nb); end
        if (nvs !== 80) begin errors++; $display("FAIL vsync_low_cycles got=%0d exp=80", nvs); end
    endtask

    task automatic test_frame_wrap();
        int sq[$];
        int oq[$];
        int c0, e;
        c0 = cyc;
        for (int n = 0; n < 8; n++) sq.push_back(c0 + n * SFRAME);
        for (int n = 0; n < 15; n++) oq.push_back(c0 + n * OFRAME);
        repeat (7 * SFRAME + 1) begin
            if (s_ft === 1'b1) begin
                checks++;
                if (sq.size() == 0) begin errors++; $display("FAIL frame_tick_extra cyc=%0d", cyc); end
                else begin
                    e = sq.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL frame_tick_cycle got=%0d exp=%0d", cyc, e); end
                end
            end
            if (o_ft === 1'b1) begin
                checks++;
                if (oq.size() == 0) begin errors++; $display("FAIL frame_tick_div1_extra cyc=%0d", cyc); end
                else begin
                    e = oq.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL frame_tick_div1 got=%0d exp=%0d", cyc, e); end
                end
            end
            @(negedge clk);
        end
        checks += 2;
        if (sq.size() != 0) begin errors++; $display("FAIL frame_tick_missing left=%0d exp=0", sq.size()); end
        if (oq.size() != 0) begin errors++; $display("FAIL frame_tick_div1_missing left=%0d exp=0", oq.size()); end
    endtask

    task automatic test_game_tick();
        int gq[$];
        int guard, e, nft, ngt;
        guard = 0; nft = 0; ngt = 0;
        while (cyc % SFRAME != 1 && guard < 2 * SFRAME) begin @(negedge clk); guard++; end
        for (int n = 1; n <= 8; n++)
            if (((cyc - 1) / SFRAME + n) % SF == 0) gq.push_back(cyc - 1 + n * SFRAME);
        repeat (8 * SFRAME) begin
            if (s_ft === 1'b1) nft++;
            if (s_gt === 1'b1) begin
                ngt++;
                checks += 2;
                if (s_ft !== 1'b1) begin errors++; $display("FAIL game_tick_coincident got=%b exp=1", s_ft); end
                if (gq.size() == 0) begin errors++; $display("FAIL game_tick_extra cyc=%0d", cyc); end
                else begin
                    e = gq.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL game_tick_cycle got=%0d exp=%0d", cyc, e); end
                end
            end
            checks++;
            if (o_gt !== o_ft) begin errors++; $display("FAIL game_eq_frame cyc=%0d got=%b exp=%b", cyc, o_gt, o_ft); end
            @(negedge clk);
        end
        checks += 3;
        if (nft !== 8) begin errors++; $display("FAIL frame_tick_count got=%0d exp=8", nft); end
        if (ngt !== 2) begin errors++; $display("FAIL game_tick_count got=%0d exp=2", ngt); end
        if (gq.size() != 0) begin errors++; $display("FAIL game_tick_missing left=%0d exp=0", gq.size()); end
    endtask

    task automatic test_mid_reset();
        int fq[$];
        out_t sb[$];
        out_t ef, es;
        int guard, e;
        guard = 0;
        while (!(s_h == 10'd10 && s_v == 10'd6) && guard < 2 * SFRAME) begin @(negedge clk); guard++; end
        checks++;
        if (s_h !== 10'd10 || s_v !== 10'd6)
            begin errors++; $display("FAIL mid_reset_reach got=%0d,%0d exp=10,6", s_h, s_v); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (full_o !== '0)  begin errors++; $display("FAIL mid_reset_full got=%h exp=0", full_o); end
        if (small_o !== '0) begin errors++; $display("FAIL mid_reset_small got=%h exp=0", small_o); end
        if (one_o !== '0)   begin errors++; $display("FAIL mid_reset_one got=%h exp=0", one_o); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fq.push_back(SFRAME);
        fq.push_back(2 * SFRAME);
        #1;
        for (int i = 0; i <= 2 * SFRAME; i++) begin
            sb.push_back(exp_full(cyc));
            sb.push_back(exp_small(cyc));
            ef = sb.pop_front();
            es = sb.pop_front();
            checks += 2;
            if (full_o !== ef)  begin errors++; $display("FAIL post_reset_full cyc=%0d got=%h exp=%h", cyc, full_o, ef); end
            if (small_o !== es) begin errors++; $display("FAIL post_reset_small cyc=%0d got=%h exp=%h", cyc, small_o, es); end
            if (s_ft === 1'b1) begin
                checks++;
                if (fq.size() == 0) begin errors++; $display("FAIL post_reset_tick_extra cyc=%0d", cyc); end
                else begin
                    e = fq.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL post_reset_tick got=%0d exp=%0d", cyc, e); end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (fq.size() != 0) begin errors++; $display("FAIL post_reset_tick_missing left=%0d exp=0", fq.size()); end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_visible_window();
        test_frame_wrap();
        test_game_tick();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the 640x480@60 Hz raster timing that the pixel colouring stage consumes: hCount, vCount, bright, hSync and vSync.
- Runs on the 100 MHz master clock and derives a one-in-four pixel enable.
- Produces a per-frame pulse, plus a slower game-rate pulse used as the clock enable for the Pac-Man movement and pellet logic. This replaces a separately divided slow clock.
- Sits directly upstream of the colour/mux stage and drives the VGA connector sync pins.

Parameters:
- CLK_DIV, 4: master clocks per pixel (minimum 1).
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low width in pixels, starting at hCount 0.
- H_VIS_START, 144: first visible hCount.
- H_VIS_END, 783: last visible hCount.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low width in lines, starting at vCount 0.
- V_VIS_START, 35: first visible vCount.
- V_VIS_END, 514: last visible vCount.
- FRAMES_PER_TICK, 4: frames per game_tick (minimum 1).

Ports:
- clk, input, 1: master clock, 100 MHz.
- rst, input, 1: asynchronous, active-high reset.
- pix_en, output, 1: one-clk pulse, once every CLK_DIV clks.
- hCount, output, 10: horizontal pixel counter, 0..H_TOTAL-1.
- vCount, output, 10: vertical line counter, 0..V_TOTAL-1.
- bright, output, 1: high inside the visible window.
- hSync, output, 1: active-low horizontal sync.
- vSync, output, 1: active-low vertical sync.
- frame_tick, output, 1: one-clk pulse at frame wrap.
- game_tick, output, 1: one-clk pulse on every FRAMES_PER_TICK-th frame_tick.

Behaviour:
- Reset (async assert, sync release): divider=0, hCount=0, vCount=0, pix_en=0, bright=0, hSync=0, vSync=0, frame_tick=0, game_tick=0, frame counter=0.
- Divider:
  - counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div==CLK_DIV-1), decoded from the register.
  - First pix_en is high during clk cycle CLK_DIV-1 after reset release.
  - CLK_DIV=1: pix_en is constantly 1 out of reset.
- Counters advance only on edges where pix_en=1:
  - hCount==H_TOTAL-1 -> hCount=0 and vCount increments.
  - Otherwise hCount increments.
  - vCount==V_TOTAL-1 at a line wrap -> vCount=0.
- hSync, vSync and bright are registered.
  - Each is computed from the next-state counter values, so it updates on the same edge as the counters and always matches them. Zero relative latency, no decode glitches.
  - hSync = !(hCount < H_SYNC).
  - vSync = !(vCount < V_SYNC).
  - bright = H_VIS_START<=hCount<=H_VIS_END && V_VIS_START<=vCount<=V_VIS_END.
- frame_tick:
  - Registered, high for exactly one clk.
  - Asserted on the edge where the counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Frame counter:
  - Counts 0..FRAMES_PER_TICK-1 and increments on each frame wrap.
  - game_tick asserts in the same clk as the frame_tick that wraps the frame counter to 0.
  - FRAMES_PER_TICK=1: game_tick is identical to frame_tick.
- No pulse is ever generated by reset assertion or release.
- Reset mid-frame returns everything to reset values immediately (asynchronously). After release, the first frame_tick occurs a full frame later.
- Width rules:
  - Counters are 10-bit unsigned.
  - Frame counter is $clog2(FRAMES_PER_TICK)+1 bits wide.
- Elaboration checks:
  - H_TOTAL and V_TOTAL <= 1024.
  - H_SYNC < H_VIS_START <= H_VIS_END < H_TOTAL, and the same ordering for vertical.
  - Any violation triggers $error.
- Nominal rates:
  - Frame = 800*525*4 = 1,680,000 clks.
  - game_tick period = 6,720,000 clks (about 14.9 Hz).

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480 timing localparams (H_TOTAL, H_SYNC, H_VIS_*, V_*).
  - Playfield origin constants 150/34 and 630/514, shared with the colour stage.
- One sub-module, tick_divider:
  - Generic modulo-N counter with an enable input, a pulse output and async reset.
  - Instantiated twice: pixel divider (N=CLK_DIV, enable=1) and frame-to-game divider (N=FRAMES_PER_TICK, enable=frame-wrap).

Test Plan:
1. Reset values: hold rst 10 clks -> all outputs 0. Release -> pix_en first high at clk 3, then every 4 clks; hCount=1 after the 4th edge.
2. Line wrap: run to hCount=799 -> next pix_en edge gives hCount=0, vCount=1. hSync is low for exactly 96 pixels (384 clks) per line and rises as hCount goes 95->96.
3. Visible window: bright goes 0->1 as hCount goes 143->144 while vCount=35, and 1->0 as hCount goes 783->784. bright=0 for all of vCount 515..524 and 0..34. vSync is low only for vCount 0..1.
4. Frame wrap: at (799,524) -> (0,0) frame_tick is one clk high. The next frame_tick comes exactly 1,680,000 clks later; there are no other pulses.
5. Game tick: run 8 frames -> game_tick is high on frame_ticks #4 and #8 only, coincident with them. FRAMES_PER_TICK=1 build -> game_tick==frame_tick every cycle.
6. Mid-operation reset: assert rst at hCount=400, vCount=200 between edges -> outputs zero immediately. After release, timing matches scenario 1 and the first frame_tick is 1,680,000 clks after the divider restarts.
